// File: rtl/nto1_muxreg_hs_if.sv
// Handshake bundle for the N:1 registered mux: per-channel inputs, one registered output stage.
// master drives the producer/consumer side; slave is the mux itself.
interface nto1_muxreg_hs_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [SELW-1:0]       out_ch;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/nto1_muxreg_hs.sv
// N:1 channel mux into a one-entry registered output stage with valid/ready handshaking.
// Grant is either a fixed select or round-robin starting after the last channel that transferred.
module nto1_muxreg_hs #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nto1_muxreg_hs_if.slave     bus
);

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SELW-1:0]  out_ch_q;
    logic [SELW-1:0]  rr_ptr;

    logic             load;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt;
    logic [NCH-1:0]   in_ready_c;

    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        if (!bus.mode) begin
            // comparing against every legal index means an out-of-range sel simply never matches
            for (int i = 0; i < NCH; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                idx = (int'(rr_ptr) + k) % NCH;
                if (!gnt_vld && bus.in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(idx);
                end
            end
        end
    end

    // reset_n gating keeps every accept strobe low while the block is held in reset
    always_comb begin
        in_ready_c = '0;
        if (reset_n && load && gnt_vld) begin
            in_ready_c[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr      <= SELW'(NCH - 1);
        end else if (load) begin
            if (gnt_vld) begin
                out_data_q  <= bus.in_data[int'(gnt)*WIDTH +: WIDTH];
                out_ch_q    <= gnt;
                out_valid_q <= 1'b1;
                rr_ptr      <= gnt;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_nto1_muxreg_hs.sv
// Directed bench for nto1_muxreg_hs: a 4-channel instance for the main flows and a
// 3-channel instance for the out-of-range select case.
module tb_nto1_muxreg_hs;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    nto1_muxreg_hs_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus4 ();
    nto1_muxreg_hs_if #(.WIDTH(8), .NCH(3), .SELW(2)) bus3 ();

    nto1_muxreg_hs #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    nto1_muxreg_hs #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ch [4];

        reset_n        = 1'b0;
        bus4.mode      = 1'b1;
        bus4.sel       = 2'd0;
        bus4.in_valid  = 4'b1111;
        bus4.in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        bus4.out_ready = 1'b1;
        bus3.mode      = 1'b0;
        bus3.sel       = 2'd0;
        bus3.in_valid  = 3'b000;
        bus3.in_data   = {8'h92, 8'h77, 8'h90};
        bus3.out_ready = 1'b1;

        // reset with every channel valid
        #22;
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus4.out_data),  32'h00);
        chk("rst_out_ch",    32'(bus4.out_ch),    32'd0);
        chk("rst_in_ready",  32'(bus4.in_ready),  32'h0);

        reset_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(bus4.in_ready), 32'b0001);

        // round-robin over all four channels
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_all_ch%0d", k),   32'(bus4.out_ch),    32'(k % 4));
            chk($sformatf("rr_all_data%0d", k), 32'(bus4.out_data),  32'(8'hC0 + (k % 4)));
            chk($sformatf("rr_all_vld%0d", k),  32'(bus4.out_valid), 32'd1);
        end

        // only ch1/ch3 valid; last grant was ch1 so the search resumes at ch2 -> ch3
        bus4.in_valid = 4'b1010;
        #1;
        chk("rr_sparse_ready", 32'(bus4.in_ready), 32'b1000);
        exp_ch = '{3, 1, 3, 1};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_sparse_ch%0d", k), 32'(bus4.out_ch), 32'(exp_ch[k]));
        end

        // fixed select ch2 streaming
        bus4.mode     = 1'b0;
        bus4.sel      = 2'd2;
        bus4.in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            bus4.in_data[2*8 +: 8] = 8'(8'h10 + k);
            #1;
            chk($sformatf("fix_ready%0d", k), 32'(bus4.in_ready), 32'b0100);
            tick();
            chk($sformatf("fix_data%0d", k), 32'(bus4.out_data), 32'(8'h10 + k));
            chk($sformatf("fix_ch%0d", k),   32'(bus4.out_ch),   32'd2);
        end

        // backpressure holding 0xA5 from ch3
        bus4.sel               = 2'd3;
        bus4.in_data[3*8 +: 8] = 8'hA5;
        tick();
        chk("bp_load_data", 32'(bus4.out_data), 32'hA5);
        bus4.out_ready         = 1'b0;
        bus4.in_data[3*8 +: 8] = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), 32'(bus4.in_ready), 32'h0);
            tick();
            chk($sformatf("bp_data%0d", k),  32'(bus4.out_data),  32'hA5);
            chk($sformatf("bp_ch%0d", k),    32'(bus4.out_ch),    32'd3);
            chk($sformatf("bp_vld%0d", k),   32'(bus4.out_valid), 32'd1);
        end
        bus4.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus4.in_ready), 32'b1000);
        tick();
        chk("bp_release_data", 32'(bus4.out_data), 32'h5A);

        // nothing valid: output drains, data holds
        bus4.in_valid = 4'b0000;
        tick();
        chk("drain_vld",  32'(bus4.out_valid), 32'd0);
        chk("drain_data", 32'(bus4.out_data),  32'h5A);

        // switching to round-robin after fixed grants on ch3 resumes at ch0
        bus4.mode     = 1'b1;
        bus4.in_valid = 4'b1111;
        tick();
        chk("switch_ch",   32'(bus4.out_ch),   32'd0);
        chk("switch_data", 32'(bus4.out_data), 32'hC0);

        // asynchronous reset between edges with a pending word
        bus4.out_ready = 1'b0;
        tick();
        chk("pre_rst_vld", 32'(bus4.out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vld",   32'(bus4.out_valid), 32'd0);
        chk("mid_rst_data",  32'(bus4.out_data),  32'h00);
        chk("mid_rst_ch",    32'(bus4.out_ch),    32'd0);
        chk("mid_rst_ready", 32'(bus4.in_ready),  32'h0);
        tick();
        chk("mid_rst_ready_edge", 32'(bus4.in_ready), 32'h0);
        reset_n        = 1'b1;
        bus4.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus4.in_ready), 32'b0001);
        tick();
        chk("post_rst_ch",   32'(bus4.out_ch),   32'd0);
        chk("post_rst_data", 32'(bus4.out_data), 32'hC0);

        // NCH=3: out-of-range select
        bus3.in_valid  = 3'b111;
        bus3.sel       = 2'd1;
        bus3.out_ready = 1'b0;
        #1;
        chk("n3_sel1_ready", 32'(bus3.in_ready), 32'b010);
        tick();
        chk("n3_load_data", 32'(bus3.out_data),  32'h77);
        chk("n3_load_ch",   32'(bus3.out_ch),    32'd1);
        bus3.sel = 2'd2;
        #1;
        chk("n3_bp_ready", 32'(bus3.in_ready), 32'b000);
        bus3.out_ready = 1'b1;
        #1;
        chk("n3_sel2_ready", 32'(bus3.in_ready), 32'b100);
        bus3.sel = 2'd3;
        #1;
        chk("n3_sel3_ready", 32'(bus3.in_ready), 32'b000);
        tick();
        chk("n3_sel3_vld",   32'(bus3.out_valid), 32'd0);
        chk("n3_sel3_data",  32'(bus3.out_data),  32'h77);
        tick();
        chk("n3_sel3_ready2", 32'(bus3.in_ready),  32'b000);
        chk("n3_sel3_vld2",   32'(bus3.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
